// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper and its settle counter.
// No logic here; latency and backpressure are defined by the users of these types.
package ttsweep_pkg;
    localparam int DEF_N_IN = 4;
    localparam int DEF_TW   = 1 << DEF_N_IN;
    localparam int STATE_W  = 2;
    localparam int SETTLE_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter timing how long each vector is held; expire is combinational on count==0.
// Load takes effect at the next edge; no backpressure, counting stops at zero until reloaded.
module settle_counter
    import ttsweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                expire
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN vectors through a function unit, capturing y and diffing against a latched table.
// Busy for TW*(SETTLE_CYCLES+1) cycles, then a one-cycle done; start is ignored unless IDLE.
module truth_table_sweeper
    import ttsweep_pkg::*;
#(
    parameter int N_IN          = DEF_N_IN,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [(2**N_IN)-1:0] expected,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic [(2**N_IN)-1:0] truth_table,
    output logic                 mismatch,
    output logic [N_IN:0]        mismatch_count,
    output logic [N_IN-1:0]      first_fail
);

    localparam int TW = 2 ** N_IN;
    localparam logic [N_IN-1:0]     LAST_IDX   = N_IN'(TW - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [TW-1:0]   expected_q;
    logic            cnt_load;
    logic            cnt_en;
    logic            settle_done;
    logic            bit_diff;

    // Reload on every DRIVE entry so each vector gets the full settle window.
    assign cnt_load = ((state == IDLE) && start) || ((state == SAMPLE) && (idx != LAST_IDX));
    assign cnt_en   = (state == DRIVE);
    assign bit_diff = (y_in != expected_q[idx]);

    settle_counter u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LD),
        .en       (cnt_en),
        .expire   (settle_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            expected_q     <= '0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            truth_table    <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q     <= expected;
                        truth_table    <= '0;
                        mismatch       <= 1'b0;
                        mismatch_count <= '0;
                        first_fail     <= '0;
                        idx            <= '0;
                        vec_out        <= '0;
                        busy           <= 1'b1;
                        state          <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_done) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    truth_table[idx] <= y_in;
                    if (bit_diff) begin
                        mismatch       <= 1'b1;
                        mismatch_count <= mismatch_count + 1'b1;
                        if (!mismatch) begin
                            first_fail <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx     <= idx + 1'b1;
                        vec_out <= idx + 1'b1;
                        state   <= DRIVE;
                    end
                end
                FINISH: begin
                    done    <= 1'b0;
                    vec_out <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: table-driven sweeps on a settle=1 instance plus corner sequences
// (mid-sweep reset, held start, settle=3 against a two-register-delayed unit).
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic [15:0] expected, expected3;
    logic [3:0]  vec_out, vec_out3;
    logic        y_in, y_in3;
    logic        busy, busy3, done, done3;
    logic [15:0] truth_table, truth_table3;
    logic        mismatch, mismatch3;
    logic [4:0]  mismatch_count, mismatch_count3;
    logic [3:0]  first_fail, first_fail3;
    logic        ymode;
    logic        dly1, dly2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic unit_f(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    assign y_in = ymode ? 1'b0 : unit_f(vec_out);

    always @(posedge clk) begin
        dly1 <= unit_f(vec_out3);
        dly2 <= dly1;
    end
    assign y_in3 = dly2;

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .vec_out(vec_out),
        .y_in(y_in), .busy(busy), .done(done), .truth_table(truth_table),
        .mismatch(mismatch), .mismatch_count(mismatch_count), .first_fail(first_fail)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(expected3), .vec_out(vec_out3),
        .y_in(y_in3), .busy(busy3), .done(done3), .truth_table(truth_table3),
        .mismatch(mismatch3), .mismatch_count(mismatch_count3), .first_fail(first_fail3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ym;
        logic [15:0] ex;
        logic [15:0] tt;
        logic        mm;
        logic [4:0]  cnt;
        logic [3:0]  ff;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int busy_n, done_n, first_done, c, bad;
        logic seen;

        vecs[0] = '{1'b0, 16'hF888, 16'hF888, 1'b0, 5'd0,  4'd0};
        vecs[1] = '{1'b0, 16'hF889, 16'hF888, 1'b1, 5'd1,  4'd0};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 5'd16, 4'd0};
        vecs[3] = '{1'b0, 16'h0000, 16'hF888, 1'b1, 5'd7,  4'd3};
        vecs[4] = '{1'b0, 16'hF808, 16'hF888, 1'b1, 5'd1,  4'd7};
        vecs[5] = '{1'b1, 16'h8000, 16'h0000, 1'b1, 5'd1,  4'd15};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; ymode = 1'b0;
        expected = '0; expected3 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset vec_out", vec_out, 0);
        check("reset truth_table", truth_table, 0);
        check("reset mismatch", mismatch, 0);
        check("reset count", mismatch_count, 0);
        check("reset first_fail", first_fail, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ymode = vecs[i].ym; expected = vecs[i].ex; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            expected = ~vecs[i].ex;
            busy_n = 0; done_n = 0; first_done = 0;
            for (int k = 1; k <= 40; k++) begin
                if (busy) busy_n++;
                if (done) begin
                    done_n++;
                    if (first_done == 0) first_done = k;
                end
                @(negedge clk);
            end
            check($sformatf("v%0d busy cycles", i), busy_n, 32);
            check($sformatf("v%0d done pulses", i), done_n, 1);
            check($sformatf("v%0d done cycle", i), first_done, 33);
            check($sformatf("v%0d truth_table", i), truth_table, vecs[i].tt);
            check($sformatf("v%0d mismatch", i), mismatch, vecs[i].mm);
            check($sformatf("v%0d count", i), mismatch_count, vecs[i].cnt);
            check($sformatf("v%0d first_fail", i), first_fail, vecs[i].ff);
        end

        // Reset while vector 7 is being driven.
        ymode = 1'b0; expected = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (vec_out == 4'd7) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst reached vec 7", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", busy, 0);
        check("rst vec_out", vec_out, 0);
        check("rst truth_table", truth_table, 0);
        check("rst mismatch", mismatch, 0);
        check("rst count", mismatch_count, 0);
        check("rst first_fail", first_fail, 0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) done_n++;
            @(negedge clk);
        end
        check("rst no done/busy after", done_n, 0);

        // start held high: back-to-back sweeps.
        expected = 16'hF888; start = 1'b1;
        done_n = 0; first_done = 0; c = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                if (done_n == 1) first_done = k;
                if (done_n == 2) c = k;
            end
            if (k == 10) check("held vec_out at 10", vec_out, 4);
            if (k == 34) check("held idle busy at 34", busy, 0);
            if (k == 50) check("held vec_out at 50", vec_out, 7);
        end
        check("held done pulses", done_n, 2);
        check("held first done", first_done, 33);
        check("held second done", c, 67);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("held third sweep done", seen, 1);
        check("held third truth_table", truth_table, 16'hF888);
        @(negedge clk);

        // Settle=3 instance against a unit delayed by two registers.
        expected3 = 16'hF888; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        expected3 = 16'h0000;
        busy_n = 0; done_n = 0; first_done = 0; bad = 0;
        for (int k = 1; k <= 72; k++) begin
            if (busy3) begin
                busy_n++;
                if (vec_out3 != 4'((k - 1) / 4)) bad++;
            end
            if (done3) begin
                done_n++;
                if (first_done == 0) first_done = k;
            end
            @(negedge clk);
        end
        check("s3 busy cycles", busy_n, 64);
        check("s3 done pulses", done_n, 1);
        check("s3 done cycle", first_done, 65);
        check("s3 vec hold violations", bad, 0);
        check("s3 truth_table", truth_table3, 16'hF888);
        check("s3 mismatch", mismatch3, 0);
        check("s3 count", mismatch_count3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
